dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage (port C, CPU) and a debug/loader DMA engine (port D).
- Sits between the EX/MEM pipeline register and the data memory.
- The CPU has fixed priority. Starvation guard and bounded DMA lock windows give DMA guaranteed access.
- Drives a stall to the pipeline whenever a CPU access is not granted.

Parameters:
DM_ADDRESS, 9, data-memory byte address width
DATA_W, 32, data width
MAX_WAIT, 4, consecutive denied DMA cycles before DMA is forced a grant (>=1)
LOCK_MAX, 8, maximum consecutive DMA grants in one locked window (>=1)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request (level, held until granted)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  DM_ADDRESS  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_funct3  in  3  CPU access size/sign
cpu_gnt  out  1  CPU access issued this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
dma_req  in  1  DMA request (level)
dma_lock  in  1  request exclusive window starting with this access
dma_we  in  1  1=write
dma_addr  in  DM_ADDRESS  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_funct3  in  3  DMA access size
dma_gnt  out  1  DMA access issued this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DATA_W  DMA read data
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_addr  out  DM_ADDRESS  memory address
mem_wdata  out  DATA_W  memory write data
mem_funct3  out  3  memory funct3
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_rd

Behaviour:
- Grants are combinational, in the same cycle as the request. At most one grant per cycle. The granted port's fields are muxed onto the mem_* outputs.
- When no port is granted: mem_rd=mem_wr=0, and mem_addr/mem_wdata/mem_funct3 = 0.
- FSM state ARB:
  - Only one requester: that requester is granted.
  - Both requesting: CPU wins, unless wait_cnt==MAX_WAIT, in which case DMA wins.
  - DMA granted with dma_lock=1: next state is LOCK, and lock_cnt is set to 1.
- FSM state LOCK:
  - CPU is never granted; cpu_stall follows cpu_req.
  - DMA is granted whenever dma_req=1, and each grant increments lock_cnt.
  - Return to ARB on the cycle after either: a granted cycle with dma_lock=0, a cycle with dma_req=0, or a grant that makes lock_cnt==LOCK_MAX.
  - On return to ARB, wait_cnt is cleared. The CPU is therefore guaranteed the next contended cycle.
- wait_cnt:
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Cleared on dma_gnt or when dma_req=0.
- Read return: a one-bit owner flag and a valid bit are registered whenever mem_rd is issued.
  - Next cycle, the owner's rvalid=1 and its rdata=mem_rdata.
  - The other port's rdata is 0.
  - Writes produce no rvalid.
- Back-to-back reads from alternating owners are supported every cycle, with no bubble.
- Reset:
  - State ARB; wait_cnt, lock_cnt and the valid bit cleared.
  - All registered outputs are 0; cpu_rvalid=dma_rvalid=0.
  - A read in flight when reset asserts is dropped, and no rvalid is produced after reset.
- Simultaneous events:
  - If the CPU wins contention, dma_lock is ignored and the lock is not entered.
  - A grant in the cycle where wait_cnt reaches MAX_WAIT goes to DMA.

Optional Feature:
- Macro DMARB_STATS_EN enabled: adds outputs stat_cpu_stall (CNT_W) and stat_dma_gnt (CNT_W).
  - stat_cpu_stall counts cycles with cpu_stall=1; stat_dma_gnt counts cycles with dma_gnt=1.
  - Both saturate at all-ones and clear on reset.
- Macro not defined: the ports and counters do not exist. Arbitration behaviour is identical in both builds.

Test Plan:
- CPU-only read, addr 0x010: cpu_gnt=1 same cycle, mem_rd=1, mem_addr=0x010; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata, dma_rvalid=0.
- Both requesters held continuously, MAX_WAIT=4: CPU granted 4 cycles, DMA granted on the 5th, pattern repeats; cpu_stall=1 exactly on DMA cycles.
- DMA lock, dma_lock=1 held, LOCK_MAX=8, CPU requesting: 8 consecutive dma_gnt, then LOCK exits; next cycle cpu_gnt=1.
- Alternating reads CPU then DMA on consecutive cycles: cpu_rvalid and dma_rvalid pulse on consecutive cycles with the correct data routing and no bubble.
- Reset asserted the cycle after a DMA mem_rd: no dma_rvalid, state ARB, all outputs 0 the following cycle.
- DMARB_STATS_EN with 10 contended cycles at MAX_WAIT=4: stat_dma_gnt=2, stat_cpu_stall=2.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, DMA and data-memory signals around dmem_arbiter.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  // CPU (MEM stage) port
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DM_ADDRESS-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [2:0]            cpu_funct3;
  logic                  cpu_gnt;
  logic                  cpu_stall;
  logic                  cpu_rvalid;
  logic [DATA_W-1:0]     cpu_rdata;

  // DMA port
  logic                  dma_req;
  logic                  dma_lock;
  logic                  dma_we;
  logic [DM_ADDRESS-1:0] dma_addr;
  logic [DATA_W-1:0]     dma_wdata;
  logic [2:0]            dma_funct3;
  logic                  dma_gnt;
  logic                  dma_rvalid;
  logic [DATA_W-1:0]     dma_rdata;

  // data-memory port
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata, dma_funct3,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata, dma_funct3,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU fixed priority, DMA starvation guard and lock windows.
// Optional statistics counters under DMARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned LOCK_MAX   = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cpu_stall,
  output logic [CNT_W-1:0] stat_dma_gnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  generate
    if (MAX_WAIT < 1 || LOCK_MAX < 1 || CNT_W < 1 || DM_ADDRESS < 1 || DATA_W < 1) begin : g_bad_param
      $error("dmem_arbiter: illegal parameter value");
    end
  endgenerate

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              rd_valid;
  logic              rd_owner;   // 1 = outstanding read belongs to DMA

  logic cpu_gnt_c;
  logic dma_gnt_c;
  logic lock_full_c;
  logic lock_exit_c;

  // Same-cycle grant decision; nothing is granted while reset is held.
  always_comb begin
    cpu_gnt_c = 1'b0;
    dma_gnt_c = 1'b0;
    if (!reset) begin
      if (state == LOCK) begin
        dma_gnt_c = bus.dma_req;
      end else if (bus.cpu_req && bus.dma_req) begin
        if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
          dma_gnt_c = 1'b1;
        end else begin
          cpu_gnt_c = 1'b1;
        end
      end else begin
        cpu_gnt_c = bus.cpu_req;
        dma_gnt_c = bus.dma_req;
      end
    end
  end

  // Lock window ends after an unlocked grant, an idle DMA cycle or the LOCK_MAX-th grant.
  always_comb begin
    lock_full_c = dma_gnt_c && (lock_cnt == LOCK_W'(LOCK_MAX - 1));
    lock_exit_c = !bus.dma_req || (dma_gnt_c && !bus.dma_lock) || lock_full_c;
  end

  // Granted port's fields onto the memory bus; idle bus is all zero.
  always_comb begin
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = DM_ADDRESS'(0);
    bus.mem_wdata  = DATA_W'(0);
    bus.mem_funct3 = 3'd0;
    if (cpu_gnt_c) begin
      bus.mem_rd     = !bus.cpu_we;
      bus.mem_wr     = bus.cpu_we;
      bus.mem_addr   = bus.cpu_addr;
      bus.mem_wdata  = bus.cpu_wdata;
      bus.mem_funct3 = bus.cpu_funct3;
    end else if (dma_gnt_c) begin
      bus.mem_rd     = !bus.dma_we;
      bus.mem_wr     = bus.dma_we;
      bus.mem_addr   = bus.dma_addr;
      bus.mem_wdata  = bus.dma_wdata;
      bus.mem_funct3 = bus.dma_funct3;
    end
  end

  // Handshake and read-return routing; an in-flight read is dropped while reset is high.
  always_comb begin
    bus.cpu_gnt    = cpu_gnt_c;
    bus.dma_gnt    = dma_gnt_c;
    bus.cpu_stall  = bus.cpu_req && !cpu_gnt_c;
    bus.cpu_rvalid = rd_valid && !rd_owner && !reset;
    bus.dma_rvalid = rd_valid &&  rd_owner && !reset;
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : DATA_W'(0);
    bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : DATA_W'(0);
  end

  // Arbitration state, starvation counter, lock counter and read-return tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      wait_cnt <= WAIT_W'(0);
      lock_cnt <= LOCK_W'(0);
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_valid <= bus.mem_rd;
      rd_owner <= dma_gnt_c;

      if (dma_gnt_c || !bus.dma_req) begin
        wait_cnt <= WAIT_W'(0);
      end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end

      case (state)
        ARB: begin
          // A one-grant window is already complete, so LOCK_MAX==1 never enters LOCK.
          if (dma_gnt_c && bus.dma_lock && (LOCK_MAX > 1)) begin
            state    <= LOCK;
            lock_cnt <= LOCK_W'(1);
          end
        end
        LOCK: begin
          if (dma_gnt_c) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
          if (lock_exit_c) begin
            state    <= ARB;
            wait_cnt <= WAIT_W'(0);
            lock_cnt <= LOCK_W'(0);
          end
        end
        default: begin
          state <= ARB;
        end
      endcase
    end
  end

`ifdef DMARB_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_stall <= CNT_W'(0);
      stat_dma_gnt   <= CNT_W'(0);
    end else begin
      if (bus.cpu_stall && !(&stat_cpu_stall)) begin
        stat_cpu_stall <= stat_cpu_stall + CNT_W'(1);
      end
      if (dma_gnt_c && !(&stat_dma_gnt)) begin
        stat_dma_gnt <= stat_dma_gnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int DM_ADDRESS = 9;
  localparam int DATA_W     = 32;
  localparam int MAX_WAIT   = 4;
  localparam int LOCK_MAX   = 8;
  localparam int CNT_W      = 16;
  localparam int STAT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  dmem_arbiter_if #(.DM_ADDRESS(DM_ADDRESS), .DATA_W(DATA_W)) bus ();

`ifdef DMARB_STATS_EN
  logic [CNT_W-1:0] stat_cpu_stall;
  logic [CNT_W-1:0] stat_dma_gnt;
`endif

  dmem_arbiter #(
    .DM_ADDRESS(DM_ADDRESS),
    .DATA_W    (DATA_W),
    .MAX_WAIT  (MAX_WAIT),
    .LOCK_MAX  (LOCK_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
`ifdef DMARB_STATS_EN
    ,
    .stat_cpu_stall(stat_cpu_stall),
    .stat_dma_gnt  (stat_dma_gnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_wait   = 0;
  bit m_locked = 0;
  int m_lockn  = 0;
  bit m_pv     = 0;
  bit m_pdma   = 0;
  int m_stall  = 0;
  int m_dgnt   = 0;

  // Observed grant counts for directed scenarios
  int obs_cgnt = 0;
  int obs_dgnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_funct3 = '0;
    bus.dma_req = 0; bus.dma_lock = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.dma_funct3 = '0;
  endtask

  // One clock: inputs already applied; check outputs mid-cycle, then advance the model.
  task automatic step();
    bit eg_c, eg_d, e_rd, e_wr, e_crv, e_drv;
    logic [DM_ADDRESS-1:0] e_addr;
    logic [DATA_W-1:0]     e_wdata, rdat;
    logic [2:0]            e_f3;
    rdat = DATA_W'($urandom());
    bus.mem_rdata = rdat;
    #3;
    eg_c = 0; eg_d = 0;
    if (!reset) begin
      if (m_locked) eg_d = bus.dma_req;
      else if (bus.cpu_req && bus.dma_req) begin
        eg_d = (m_wait == MAX_WAIT);
        eg_c = !eg_d;
      end else begin
        eg_c = bus.cpu_req;
        eg_d = bus.dma_req;
      end
    end
    e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_f3 = '0;
    if (eg_c) begin
      e_rd = !bus.cpu_we; e_wr = bus.cpu_we; e_addr = bus.cpu_addr;
      e_wdata = bus.cpu_wdata; e_f3 = bus.cpu_funct3;
    end else if (eg_d) begin
      e_rd = !bus.dma_we; e_wr = bus.dma_we; e_addr = bus.dma_addr;
      e_wdata = bus.dma_wdata; e_f3 = bus.dma_funct3;
    end
    e_crv = !reset && m_pv && !m_pdma;
    e_drv = !reset && m_pv && m_pdma;

    check("cpu_gnt",    64'(bus.cpu_gnt),    64'(eg_c));
    check("dma_gnt",    64'(bus.dma_gnt),    64'(eg_d));
    check("cpu_stall",  64'(bus.cpu_stall),  64'(bus.cpu_req && !eg_c));
    check("mem_rd",     64'(bus.mem_rd),     64'(e_rd));
    check("mem_wr",     64'(bus.mem_wr),     64'(e_wr));
    check("mem_addr",   64'(bus.mem_addr),   64'(e_addr));
    check("mem_wdata",  64'(bus.mem_wdata),  64'(e_wdata));
    check("mem_funct3", 64'(bus.mem_funct3), 64'(e_f3));
    check("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(e_crv));
    check("cpu_rdata",  64'(bus.cpu_rdata),  e_crv ? 64'(rdat) : 64'd0);
    check("dma_rvalid", 64'(bus.dma_rvalid), 64'(e_drv));
    check("dma_rdata",  64'(bus.dma_rdata),  e_drv ? 64'(rdat) : 64'd0);
`ifdef DMARB_STATS_EN
    check("stat_cpu_stall", 64'(stat_cpu_stall), 64'(m_stall));
    check("stat_dma_gnt",   64'(stat_dma_gnt),   64'(m_dgnt));
`endif
    obs_cgnt += int'(bus.cpu_gnt);
    obs_dgnt += int'(bus.dma_gnt);

    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_locked = 0; m_lockn = 0; m_pv = 0; m_pdma = 0;
      m_stall = 0; m_dgnt = 0;
    end else begin
      m_pv   = e_rd;
      m_pdma = eg_d;
      if (bus.cpu_req && !eg_c && m_stall < STAT_MAX) m_stall++;
      if (eg_d && m_dgnt < STAT_MAX) m_dgnt++;
      if (eg_d || !bus.dma_req) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (m_locked) begin
        if (eg_d) m_lockn++;
        if (!bus.dma_req || (eg_d && !bus.dma_lock) || m_lockn >= LOCK_MAX) begin
          m_locked = 0; m_wait = 0; m_lockn = 0;
        end
      end else if (eg_d && bus.dma_lock && LOCK_MAX > 1) begin
        m_locked = 1; m_lockn = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs(); step(); step(); reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    bus.mem_rdata = '0;
    #1;
    do_reset();

    // CPU-only read of 0x010
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 9'h010; bus.cpu_funct3 = 3'd2;
    obs_cgnt = 0;
    step();
    check("cpu_read_gnt", 64'(obs_cgnt), 64'd1);
    idle_inputs();
    step();

    // Sustained contention: CPU x4, DMA x1, repeating
    do_reset();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 9'h020; bus.cpu_wdata = 32'h1111_2222;
    bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 9'h1F0; bus.dma_wdata = 32'hAAAA_5555;
    obs_cgnt = 0; obs_dgnt = 0;
    for (int i = 0; i < 10; i++) step();
    check("contend_cpu_gnts", 64'(obs_cgnt), 64'd8);
    check("contend_dma_gnts", 64'(obs_dgnt), 64'd2);
`ifdef DMARB_STATS_EN
    check("contend_stat_dma",   64'(stat_dma_gnt),   64'd2);
    check("contend_stat_stall", 64'(stat_cpu_stall), 64'd2);
`endif

    // Lock window: 4 CPU wins, then 8 locked DMA grants, then CPU again
    do_reset();
    bus.cpu_req = 1; bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 0; bus.cpu_we = 0;
    obs_cgnt = 0; obs_dgnt = 0;
    for (int i = 0; i < 12; i++) step();
    check("lock_dma_run", 64'(obs_dgnt), 64'd8);
    obs_cgnt = 0;
    step();
    check("lock_exit_cpu", 64'(obs_cgnt), 64'd1);
    idle_inputs();
    step();

    // Alternating single-requester reads: CPU, DMA, CPU, DMA
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin
        bus.cpu_req = 1; bus.cpu_addr = DM_ADDRESS'(i * 4);
      end else begin
        bus.dma_req = 1; bus.dma_addr = DM_ADDRESS'(9'h100 + i * 4);
      end
      step();
    end
    idle_inputs();
    step();

    // DMA read followed immediately by reset: the return must be dropped
    bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 9'h0AC;
    step();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.cpu_req    = ($urandom_range(0, 9) < 6);
      bus.cpu_we     = 1'($urandom());
      bus.cpu_addr   = DM_ADDRESS'($urandom());
      bus.cpu_wdata  = DATA_W'($urandom());
      bus.cpu_funct3 = 3'($urandom());
      bus.dma_req    = ($urandom_range(0, 9) < 6);
      bus.dma_lock   = ($urandom_range(0, 2) == 0);
      bus.dma_we     = 1'($urandom());
      bus.dma_addr   = DM_ADDRESS'($urandom());
      bus.dma_wdata  = DATA_W'($urandom());
      bus.dma_funct3 = 3'($urandom());
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
